// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate unit: applies one single-bit step per clock.
// Carry threads between steps, so the result is a multi-bit shift or a rotate through carry.
package shifter_types;
   typedef enum logic [1:0] {
      SHL = 2'd0,
      SHR = 2'd1,
      ROL = 2'd2,
      ROR = 2'd3
   } cmd_t;
endpackage

module shift_sequencer
   import shifter_types::*;
#(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  cmd_t             cmd,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic [CNTW-1:0]  amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] data,
   output logic             C,
   output logic             Z
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_n;
   cmd_t             cmd_r, cmd_n;
   logic [CNTW-1:0]  cnt, cnt_n;
   logic [WIDTH-1:0] data_n;
   logic             c_n;
   logic             z_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cmd_r <= SHL;
         cnt   <= '0;
         data  <= '0;
         C     <= 1'b0;
         Z     <= 1'b0;
      end else begin
         state <= state_n;
         cmd_r <= cmd_n;
         cnt   <= cnt_n;
         data  <= data_n;
         C     <= c_n;
         Z     <= z_n;
      end
   end

   always_comb begin
      state_n = state;
      cmd_n   = cmd_r;
      cnt_n   = cnt;
      data_n  = data;
      c_n     = C;
      z_n     = Z;
      unique case (state)
         IDLE: begin
            if (start) begin
               data_n  = B;
               c_n     = Cin;
               cmd_n   = cmd;
               cnt_n   = amount;
               state_n = (amount != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            unique case (cmd_r)
               SHL: begin
                  c_n    = data[WIDTH-1];
                  data_n = {data[WIDTH-2:0], 1'b0};
               end
               SHR: begin
                  c_n    = data[0];
                  data_n = {1'b0, data[WIDTH-1:1]};
               end
               ROL: begin
                  c_n    = data[WIDTH-1];
                  data_n = {data[WIDTH-2:0], C};
               end
               ROR: begin
                  c_n    = data[0];
                  data_n = {C, data[WIDTH-1:1]};
               end
               default: begin
                  c_n    = 1'b0;
                  data_n = '0;
               end
            endcase
            cnt_n = cnt - 1'b1;
            if (cnt == CNTW'(1)) state_n = DONE;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      // Z is registered on entry to DONE so it is valid alongside done
      if (state_n == DONE) z_n = (data_n == '0);
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer.
// Expected values are hand-computed from the step rules.
module tb_shift_sequencer;
   import shifter_types::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   cmd_t        cmd;
   logic [31:0] B;
   logic        Cin;
   logic [4:0]  amount;
   logic        busy, done, C, Z;
   logic [31:0] data;

   int total = 0;
   int bad   = 0;

   shift_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd),
      .B(B), .Cin(Cin), .amount(amount),
      .busy(busy), .done(done), .data(data),
      .C(C), .Z(Z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input cmd_t c,
                         input logic [31:0] b, input logic ci,
                         input logic [4:0] a, input logic [31:0] ed,
                         input logic ec, input logic ez);
      int k;
      int nb;
      bit seen;
      @(negedge clk);
      cmd = c; B = b; Cin = ci; amount = a; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // scramble inputs while busy; they must not matter
      B = ~b; Cin = ~ci; amount = 5'd31; cmd = ROR;
      k = 0; nb = 0; seen = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i > 1) @(negedge clk);
         if (busy) nb++;
         if (done) begin
            k = i;
            seen = 1;
            break;
         end
      end
      chk({tag, "_lat"}, seen ? k : 0, 32'(a) + 1);
      chk({tag, "_busy"}, nb, 32'(a) + 1);
      chk({tag, "_data"}, data, ed);
      chk({tag, "_c"}, 32'(C), 32'(ec));
      chk({tag, "_z"}, 32'(Z), 32'(ez));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 0);
   endtask

   initial begin
      int nd;
      int k;
      rst = 1'b1; start = 1'b0; cmd = SHL;
      B = 32'hFFFF_FFFF; Cin = 1'b1; amount = 5'd0;
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_data", data, 0);
      chk("rst_c", 32'(C), 0);
      chk("rst_z", 32'(Z), 0);

      run_op("shl4", SHL, 32'h0000_0001, 1'b0, 5'd4,
             32'h0000_0010, 1'b0, 1'b0);
      run_op("shr2", SHR, 32'h8000_0003, 1'b0, 5'd2,
             32'h2000_0000, 1'b1, 1'b0);
      run_op("rol1", ROL, 32'h8000_0000, 1'b0, 5'd1,
             32'h0000_0000, 1'b1, 1'b1);
      run_op("rol2", ROL, 32'h8000_0000, 1'b0, 5'd2,
             32'h0000_0001, 1'b0, 1'b0);
      run_op("ror1", ROR, 32'h0000_0001, 1'b1, 5'd1,
             32'h8000_0000, 1'b1, 1'b0);
      run_op("amt0", SHR, 32'h1234_ABCD, 1'b1, 5'd0,
             32'h1234_ABCD, 1'b1, 1'b0);
      run_op("shl31", SHL, 32'h0000_0003, 1'b0, 5'd31,
             32'h8000_0000, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      chk("hold_data", data, 32'h8000_0000);
      chk("hold_c", 32'(C), 1);

      // extra starts while busy are ignored
      cmd = SHL; B = 32'h0000_0003; Cin = 1'b0; amount = 5'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0; k = 0;
      for (int i = 1; i <= 16; i++) begin
         if (i > 1) @(negedge clk);
         if (i >= 3 && i <= 6) begin
            start = 1'b1; cmd = ROR;
            B = 32'hFFFF_FFFF; Cin = 1'b1; amount = 5'd1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            nd++;
            if (k == 0) k = i;
            chk("busy_data", data, 32'h0000_0C00);
            chk("busy_c", 32'(C), 0);
         end
      end
      start = 1'b0;
      chk("busy_ndone", nd, 1);
      chk("busy_lat", k, 11);

      // reset mid-operation aborts without done
      @(negedge clk);
      cmd = SHL; B = 32'h0000_00FF; Cin = 1'b1; amount = 5'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      for (int i = 1; i <= 14; i++) begin
         if (i > 1) @(negedge clk);
         if (done) nd++;
         if (i == 4) rst = 1'b1;
         if (i == 5) begin
            rst = 1'b0;
            chk("abort_busy", 32'(busy), 0);
            chk("abort_data", data, 0);
            chk("abort_c", 32'(C), 0);
            chk("abort_z", 32'(Z), 0);
         end
      end
      chk("abort_ndone", nd, 0);

      run_op("post_ror3", ROR, 32'h0000_0005, 1'b0, 5'd3,
             32'h4000_0000, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
